// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, defaults, state type and helpers for the fetch stage
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  PC_STEP_DEFAULT  = 32'd4;
  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'd0;
  localparam logic [INSTR_W-1:0] NOP_WORD         = 32'd0;

  // RUN: normal sequential fetch; FLUSH: first cycle after a redirect
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  // Drop the byte offset so the PC always points at a whole word
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - valid/ready handshake between fetch and decode
interface instruction_fetch_if;
  import fetch_pkg::*;

  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;

  // Fetch side produces the word, decode side applies backpressure
  modport master (output if_valid, output if_instr, output if_pc, input if_ready);
  modport slave  (input if_valid, input if_instr, input if_pc, output if_ready);

endinterface

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - program counter register with increment, wrap and redirect
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [ADDR_W-1:0] PC_STEP   = PC_STEP_DEFAULT,
  parameter int                MEM_DEPTH = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc_q,
  output logic              wrap_pulse,
  output logic              misalign_pulse
);

  // One extra bit so the increment and the limit compare never overflow
  typedef logic [ADDR_W:0] wide_t;

  localparam wide_t WRAP_LIMIT = wide_t'(MEM_DEPTH) - wide_t'(PC_STEP);
  localparam wide_t DEPTH_WIDE = wide_t'(MEM_DEPTH);

  wide_t             inc_wide;
  logic              inc_wraps;
  logic [ADDR_W-1:0] target_al;
  logic              target_oob;

  assign inc_wide   = {1'b0, pc_q} + {1'b0, PC_STEP};
  assign inc_wraps  = inc_wide > WRAP_LIMIT;
  assign target_al  = align_word(target);
  assign target_oob = {1'b0, target_al} >= DEPTH_WIDE;

  // Redirect beats sequential advance; wrap and misalign are single-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      wrap_pulse     <= 1'b0;
      misalign_pulse <= 1'b0;
    end else begin
      wrap_pulse     <= 1'b0;
      misalign_pulse <= 1'b0;
      if (redirect) begin
        misalign_pulse <= |target[1:0];
        if (target_oob) begin
          pc_q       <= RESET_PC;
          wrap_pulse <= 1'b1;
        end else begin
          pc_q <= target_al;
        end
      end else if (advance) begin
        if (inc_wraps) begin
          pc_q       <= RESET_PC;
          wrap_pulse <= 1'b1;
        end else begin
          pc_q <= inc_wide[ADDR_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, memory address, output register, flush FSM, counter
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [ADDR_W-1:0] PC_STEP   = PC_STEP_DEFAULT,
  parameter int                MEM_DEPTH = 65536,
  parameter int                CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_data,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  instruction_fetch_if.master dec,
  output logic                misalign_err,
  output logic                wrap_evt,
  output logic [CNT_W-1:0]    fetch_count
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc_q;
  logic              can_issue;
  logic              fire;

  // FLUSH always has an empty output register, so it can always take a word
  assign can_issue = (state == FLUSH) || !dec.if_valid || dec.if_ready;
  assign fire      = can_issue && !stall && !branch_taken;
  assign imem_addr = pc_q;

  fetch_pc_gen #(
    .RESET_PC  (RESET_PC),
    .PC_STEP   (PC_STEP),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_pc_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .advance        (fire),
    .redirect       (branch_taken),
    .target         (branch_target),
    .pc_q           (pc_q),
    .wrap_pulse     (wrap_evt),
    .misalign_pulse (misalign_err)
  );

  // Flush FSM, decode-facing output register and fetch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      dec.if_valid <= 1'b0;
      dec.if_instr <= NOP_WORD;
      dec.if_pc    <= '0;
      fetch_count  <= '0;
    end else begin
      if (branch_taken) begin
        // A same-cycle accept by decode still takes the old word; anything after is dropped
        state        <= FLUSH;
        dec.if_valid <= 1'b0;
      end else begin
        state <= RUN;
        if (fire) begin
          dec.if_instr <= imem_data;
          dec.if_pc    <= pc_q;
          dec.if_valid <= 1'b1;
          fetch_count  <= fetch_count + 1'b1;
        end else if (can_issue && dec.if_valid && dec.if_ready) begin
          // Stalled while decode drained the register: leave a bubble
          dec.if_valid <= 1'b0;
        end
      end
    end
  end

endmodule
